// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding.
package uart_arb_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// i_last_owner+1, wrapping modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_owner,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;
  logic             w_hi_vld;
  logic             w_lo_vld;

  // Lowest set index above last_owner wins; otherwise lowest at or below it.
  always_comb begin
    w_hi_idx = '0;
    w_lo_idx = '0;
    w_hi_vld = 1'b0;
    w_lo_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        if (IDX_W'(i) > i_last_owner) begin
          w_hi_idx = IDX_W'(i);
          w_hi_vld = 1'b1;
        end else begin
          w_lo_idx = IDX_W'(i);
          w_lo_vld = 1'b1;
        end
      end
    end
  end

  assign o_winner = w_hi_vld ? w_hi_idx : w_lo_idx;
  assign o_valid  = w_hi_vld | w_lo_vld;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources,
// with bounded bursts and a per-byte completion timeout.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          hold,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      active,
  output logic                      timeout_err,
  output logic [STATE_W-1:0]        state_o
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned TMO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_last, w_last_nxt;
  logic [BURST_W-1:0] r_burst, w_burst_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic [DATA_W-1:0]  r_tx_data, w_tx_data_nxt;
  logic               r_active, w_active_nxt;
  logic               r_timeout_err, w_timeout_err_nxt;

  logic [IDX_W-1:0]   w_pick;
  logic               w_pick_vld;
  logic [DATA_W-1:0]  w_own_data;
  logic [N_REQ-1:0]   w_own_onehot;
  logic               w_own_req;
  logic               w_own_hold;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req        (req),
    .i_last_owner (r_last),
    .o_winner     (w_pick),
    .o_valid      (w_pick_vld)
  );

  // Per-owner views of the request bundle.
  always_comb begin
    w_own_data   = '0;
    w_own_onehot = '0;
    w_own_req    = 1'b0;
    w_own_hold   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == IDX_W'(i)) begin
        w_own_data      = req_data[i*DATA_W +: DATA_W];
        w_own_onehot[i] = 1'b1;
        w_own_req       = req[i];
        w_own_hold      = hold[i];
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_last_nxt        = r_last;
    w_burst_nxt       = r_burst;
    w_tmo_nxt         = r_tmo;
    w_gnt_nxt         = '0;
    w_tx_start_nxt    = 1'b0;
    w_tx_data_nxt     = '0;
    w_timeout_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_pick_vld) begin
          w_owner_nxt = w_pick;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_gnt_nxt      = w_own_onehot;
        w_tx_start_nxt = 1'b1;
        w_tx_data_nxt  = w_own_data;
        w_tmo_nxt      = '0;
        w_state_nxt    = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (enable && w_own_hold && w_own_req &&
              (r_burst < BURST_W'(MAX_BURST - 1))) begin
            w_burst_nxt = r_burst + BURST_W'(1);
            w_state_nxt = SEND;
          end else begin
            w_last_nxt  = r_owner;
            w_burst_nxt = '0;
            w_state_nxt = IDLE;
          end
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_timeout_err_nxt = 1'b1;
          w_last_nxt        = r_owner;
          w_burst_nxt       = '0;
          w_state_nxt       = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_active_nxt = (w_state_nxt == SEND) || (w_state_nxt == WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_owner       <= '0;
      r_last        <= IDX_W'(N_REQ - 1);
      r_burst       <= '0;
      r_tmo         <= '0;
      r_gnt         <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_active      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_last        <= w_last_nxt;
      r_burst       <= w_burst_nxt;
      r_tmo         <= w_tmo_nxt;
      r_gnt         <= w_gnt_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_active      <= w_active_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign owner       = r_owner;
  assign active      = r_active;
  assign timeout_err = r_timeout_err;
  assign state_o     = r_state;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: rotation, bursts, timeout, enable gating, reset.
module tb_uart_tx_arb;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 8;

  logic                     clk;
  logic                     reset_n;
  logic                     enable;
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         hold;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic [N_REQ-1:0]         gnt;
  logic                     tx_start;
  logic [DATA_W-1:0]        tx_data;
  logic                     tx_done;
  logic [1:0]               owner;
  logic                     active;
  logic                     timeout_err;
  logic [1:0]               state_o;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_arb #(
    .N_REQ     (N_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (4),
    .TIMEOUT   (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .req         (req),
    .hold        (hold),
    .req_data    (req_data),
    .gnt         (gnt),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .owner       (owner),
    .active      (active),
    .timeout_err (timeout_err),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until a grant pulse appears; idx=-1 if none within max_cyc.
  task automatic wait_gnt(input int max_cyc, output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    while (idx < 0 && cyc < max_cyc) begin
      step();
      cyc++;
      for (int i = 0; i < N_REQ; i++) if (gnt[i]) idx = i;
    end
  endtask

  task automatic finish_byte();
    repeat (2) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  int idx, cyc, n, seen;
  int exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    req      = '0;
    hold     = '0;
    tx_done  = 1'b0;
    req_data = 32'hA3A2A1A0;
    repeat (2) step();
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_txdata", 32'(tx_data), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    reset_n = 1'b1;
    step();

    // req=1010 after reset: requester 1 then 3
    req = 4'b1010;
    wait_gnt(8, idx, cyc);
    check_eq("a_idx", 32'(idx), 32'd1);
    check_eq("a_lat", 32'(cyc), 32'd2);
    check_eq("a_data", 32'(tx_data), 32'hA1);
    check_eq("a_start", 32'(tx_start), 32'd1);
    check_eq("a_state", 32'(state_o), 32'd2);
    check_eq("a_owner", 32'(owner), 32'd1);
    step();
    check_eq("a_gnt_clr", 32'(gnt), 32'd0);
    check_eq("a_data_clr", 32'(tx_data), 32'd0);
    check_eq("a_start_clr", 32'(tx_start), 32'd0);
    check_eq("a_active", 32'(active), 32'd1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_eq("a_idle", 32'(state_o), 32'd0);
    check_eq("a_idle_active", 32'(active), 32'd0);
    wait_gnt(8, idx, cyc);
    check_eq("b_idx", 32'(idx), 32'd3);
    check_eq("b_lat", 32'(cyc), 32'd2);
    check_eq("b_data", 32'(tx_data), 32'hA3);
    finish_byte();

    // All requesting, no hold: strict rotation with an IDLE between owners
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(8, idx, cyc);
      check_eq($sformatf("rr_idx%0d", k), 32'(idx), 32'(exp_rr[k]));
      check_eq($sformatf("rr_lat%0d", k), 32'(cyc), 32'd2);
      finish_byte();
      check_eq($sformatf("rr_idle%0d", k), 32'(state_o), 32'd0);
    end
    req = '0;

    // Burst: four back-to-back bytes for requester 2, then requester 1
    req  = 4'b0100;
    hold = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(8, idx, cyc);
      check_eq($sformatf("bu_idx%0d", k), 32'(idx), 32'd2);
      check_eq($sformatf("bu_lat%0d", k), 32'(cyc), (k == 0) ? 32'd2 : 32'd1);
      if (k == 0) req = 4'b0110;
      finish_byte();
      check_eq($sformatf("bu_state%0d", k), 32'(state_o), (k == 3) ? 32'd0 : 32'd1);
    end
    wait_gnt(8, idx, cyc);
    check_eq("bu_next_idx", 32'(idx), 32'd1);
    finish_byte();
    hold = '0;
    req  = '0;

    // Timeout: no tx_done for requester 2
    req = 4'b1100;
    wait_gnt(8, idx, cyc);
    check_eq("to_idx", 32'(idx), 32'd2);
    n = 0;
    while (!timeout_err && n < 40) begin
      step();
      n++;
    end
    check_eq("to_delay", 32'(n), 32'd16);
    check_eq("to_state", 32'(state_o), 32'd0);
    check_eq("to_active", 32'(active), 32'd0);
    step();
    check_eq("to_pulse", 32'(timeout_err), 32'd0);
    wait_gnt(8, idx, cyc);
    check_eq("to_next_idx", 32'(idx), 32'd3);
    check_eq("to_next_lat", 32'(cyc), 32'd1);
    finish_byte();
    req = '0;

    // Enable dropped mid-byte with hold active
    req  = 4'b0001;
    hold = 4'b0001;
    wait_gnt(8, idx, cyc);
    check_eq("en_idx", 32'(idx), 32'd0);
    enable = 1'b0;
    finish_byte();
    check_eq("en_idle", 32'(state_o), 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (gnt != '0) seen++;
    end
    check_eq("en_nogrant", 32'(seen), 32'd0);
    check_eq("en_hold_idle", 32'(state_o), 32'd0);
    enable = 1'b1;
    wait_gnt(8, idx, cyc);
    check_eq("en_back_idx", 32'(idx), 32'd0);
    check_eq("en_back_lat", 32'(cyc), 32'd2);
    hold = '0;
    req  = '0;
    finish_byte();

    // Asynchronous reset while a grant pulse is on the outputs
    req = 4'b0010;
    wait_gnt(8, idx, cyc);
    check_eq("rs_pre_idx", 32'(idx), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rs_gnt", 32'(gnt), 32'd0);
    check_eq("rs_start", 32'(tx_start), 32'd0);
    check_eq("rs_data", 32'(tx_data), 32'd0);
    check_eq("rs_active", 32'(active), 32'd0);
    check_eq("rs_state", 32'(state_o), 32'd0);
    check_eq("rs_owner", 32'(owner), 32'd0);
    req = 4'b1001;
    repeat (2) step();
    reset_n = 1'b1;
    wait_gnt(8, idx, cyc);
    check_eq("rs_post_idx", 32'(idx), 32'd0);
    check_eq("rs_post_lat", 32'(cyc), 32'd2);
    check_eq("rs_post_data", 32'(tx_data), 32'hA0);
    finish_byte();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
